conv_sched: RTL and testbench
=============================

Name: conv_sched

Overview:
- Round-robin scheduler that shares one convertor engine between NUM_REQ requesters.
- Accepts one request at a time (operand plus conversion mode) and issues a single-cycle start to the engine.
- Waits for engine completion, then returns the result to the granted requester.
- Sits between the requester ports and the convertor datapath core, in the same role a CPU plays when driving the converter through its register interface.

Parameters:
NUM_REQ, 4, number of requesters (>=2); GRANT_W = $clog2(NUM_REQ)
DATA_WIDTH, 8, operand/result width
MODE_WIDTH, 2, conversion-mode code width
TIMEOUT_CYCLES, 16, watchdog limit in WAIT (used only with CONV_SCHED_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_operand  in  NUM_REQ*DATA_WIDTH  packed operands, requester i at slice i
req_mode  in  NUM_REQ*MODE_WIDTH  packed mode codes
rsp_valid  out  NUM_REQ  one-cycle response pulse to granted requester
rsp_data  out  DATA_WIDTH  result, shared bus, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
eng_start  out  1  one-cycle start pulse to engine
eng_operand  out  DATA_WIDTH  operand to engine, held from ISSUE through WAIT
eng_mode  out  MODE_WIDTH  mode to engine, held like eng_operand
eng_done  in  1  engine completion pulse
eng_result  in  DATA_WIDTH  engine result, valid with eng_done
sched_idle  out  1  high when in IDLE
grant_id  out  GRANT_W  index of current/last granted requester

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; rr_ptr=0; grant_id=0.
  - Holding registers, eng_operand, eng_mode and rsp_data are 0.
  - All pulse outputs are 0; sched_idle=1.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready is combinational: req_ready[winner]=1 only in IDLE.
  - Transfer occurs at the edge where req_valid & req_ready. At that edge: capture operand/mode, set grant_id=winner, go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: eng_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - eng_done is sampled only in WAIT; a done pulse in ISSUE or IDLE is ignored.
  - On eng_done: capture eng_result into rsp_data, rsp_err=0, go to RESP.
- RESP:
  - rsp_valid[grant_id]=1 for one cycle; no backpressure.
  - rr_ptr = (grant_id+1) mod NUM_REQ; go to IDLE.
  - rsp_data and rsp_err hold until the next RESP.
- Latency: accept edge T; eng_start in cycle T+1; done earliest in T+2; rsp_valid in T+3; next accept possible at the end of T+4. Throughput is at most one conversion per 4 cycles.
- Fairness: the just-served requester gets lowest priority. Any requester holding req_valid is served within NUM_REQ grants.
- Withdrawn request: requesters may drop req_valid before acceptance with no effect. Inputs are ignored outside IDLE.
- Simultaneous requests: only the winner is accepted; all others see req_ready=0.
- Reset mid-operation: the transaction is abandoned, no rsp_valid is issued, and a late eng_done after reset is ignored.

Optional Feature:
CONV_SCHED_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without eng_done, go to RESP with rsp_data=0 and rsp_err=1.
  - If eng_done and the timeout occur in the same cycle, eng_done wins.
- Undefined: WAIT blocks indefinitely; rsp_err is tied to 0; no counter logic is generated.

Decomposition:
- Package conv_pkg holds:
  - DATA_WIDTH and MODE_WIDTH constants;
  - enum sched_state_t {IDLE, ISSUE, WAIT, RESP};
  - mode code constants.
- Sub-module conv_rr_arbiter: combinational. Takes req mask and rr_ptr; returns one-hot grant, index and any_valid.

Test Plan:
- Single request: req_valid[2]=1, operand 8'hA5, mode 2'b01, engine returns 8'h3C two cycles after start -> one eng_start pulse with eng_operand=A5/eng_mode=1; rsp_valid[2] pulse with rsp_data=3C; grant_id=2.
- All four valid continuously, engine 1-cycle latency -> grant order 0,1,2,3,0; each rsp_valid 4 cycles apart; no requester served twice in a row.
- Fairness: rr_ptr=3 after serving 2; requests from 0 and 3 -> 3 served first, then 0.
- Spurious done: eng_done asserted in IDLE and in ISSUE -> no state change, no rsp_valid.
- Reset during WAIT, then eng_done -> sched_idle=1 immediately, rr_ptr=0, no rsp_valid.
- With CONV_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, engine never responds -> rsp_valid after 16 WAIT cycles with rsp_err=1, rsp_data=0. Without the macro the scheduler stays in WAIT.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convertor scheduler.
//   DATA_WIDTH / MODE_WIDTH : default operand/result and mode-code widths
//   sched_state_t           : scheduler FSM state encoding
//   MODE_*                  : conversion-mode codes understood by the engine
package conv_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int MODE_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam logic [MODE_WIDTH-1:0] MODE_BIN2BCD  = 2'd0;
  localparam logic [MODE_WIDTH-1:0] MODE_BCD2BIN  = 2'd1;
  localparam logic [MODE_WIDTH-1:0] MODE_BIN2GRAY = 2'd2;
  localparam logic [MODE_WIDTH-1:0] MODE_GRAY2BIN = 2'd3;

endpackage

// File: rtl/conv_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at rr_ptr and wrapping; the first set bit wins.
// Ports:
//   req       in  : request mask
//   rr_ptr    in  : highest-priority index (must be < NUM_REQ)
//   grant     out : one-hot winner (zero when no request)
//   grant_idx out : winner index (0 when no request)
//   any_valid out : at least one request present
module conv_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GRANT_W-1:0] grant_idx,
  output logic               any_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req[idx]) begin
        any_valid  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = GRANT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Round-robin scheduler sharing one convertor engine between NUM_REQ
// requesters. One request is accepted in IDLE, a single-cycle eng_start is
// issued, the scheduler waits for eng_done and returns the result to the
// granted requester with a one-cycle rsp_valid pulse.
//
// Optional build macro: CONV_SCHED_TIMEOUT_EN
//   defined   : WAIT is bounded by TIMEOUT_CYCLES; expiry responds with
//               rsp_data=0, rsp_err=1 (a same-cycle eng_done still wins)
//   undefined : WAIT blocks until eng_done, rsp_err is constant 0
//
// Ports:
//   clk, reset                : clock, async active-high reset
//   req_valid/req_ready       : per-requester handshake (ready is one-hot or 0)
//   req_operand/req_mode      : packed per-requester operand and mode
//   rsp_valid/rsp_data/rsp_err: response pulse to the granted requester
//   eng_start/eng_operand/
//   eng_mode                  : engine command (operand/mode held until next accept)
//   eng_done/eng_result       : engine completion, sampled only in WAIT
//   sched_idle                : high while in IDLE
//   grant_id                  : current/last granted requester
//
// state | meaning
// IDLE  | arbitrate, accept winner on req_valid & req_ready
// ISSUE | eng_start pulse high
// WAIT  | wait for eng_done (or timeout when enabled)
// RESP  | rsp_valid pulse high, advance rr_ptr past the served requester
module conv_sched
  import conv_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GRANT_W        = $clog2(NUM_REQ),
  parameter int DATA_WIDTH     = conv_pkg::DATA_WIDTH,
  parameter int MODE_WIDTH     = conv_pkg::MODE_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand,
  input  logic [NUM_REQ*MODE_WIDTH-1:0] req_mode,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          eng_start,
  output logic [DATA_WIDTH-1:0]         eng_operand,
  output logic [MODE_WIDTH-1:0]         eng_mode,
  input  logic                          eng_done,
  input  logic [DATA_WIDTH-1:0]         eng_result,
  output logic                          sched_idle,
  output logic [GRANT_W-1:0]            grant_id
);

  sched_state_t       state;
  logic [GRANT_W-1:0] rr_ptr;
  logic [NUM_REQ-1:0] win_onehot;
  logic [GRANT_W-1:0] win_idx;
  logic               win_any;
  logic [GRANT_W-1:0] next_ptr;

  conv_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .any_valid (win_any)
  );

  assign req_ready = (state == IDLE) ? win_onehot : '0;

  // Served requester drops to lowest priority.
  assign next_ptr = (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef CONV_SCHED_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Down-counter loaded on entry to WAIT; reaching zero marks the last
  // allowed WAIT cycle, i.e. TIMEOUT_CYCLES cycles spent in WAIT.
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      eng_operand <= '0;
      eng_mode    <= '0;
      eng_start   <= 1'b0;
      rsp_data    <= '0;
      rsp_valid   <= '0;
      sched_idle  <= 1'b1;
`ifdef CONV_SCHED_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      eng_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (win_any) begin
            eng_operand <= req_operand[win_idx*DATA_WIDTH +: DATA_WIDTH];
            eng_mode    <= req_mode[win_idx*MODE_WIDTH +: MODE_WIDTH];
            grant_id    <= win_idx;
            eng_start   <= 1'b1;
            sched_idle  <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef CONV_SCHED_TIMEOUT_EN
          tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            rsp_data  <= eng_result;
            rsp_valid <= NUM_REQ'(1) << grant_id;
            state     <= RESP;
`ifdef CONV_SCHED_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (tmo_cnt == '0) begin
            rsp_data  <= '0;
            err_q     <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << grant_id;
            state     <= RESP;
          end else begin
            tmo_cnt   <= tmo_cnt - 1'b1;
`endif
          end
        end
        RESP: begin
          rr_ptr     <= next_ptr;
          sched_idle <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sched.sv
module tb_conv_sched;

  localparam int N  = 4;
  localparam int GW = 2;
  localparam int DW = 8;
  localparam int MW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_operand;
  logic [N*MW-1:0] req_mode;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            eng_start;
  logic [DW-1:0]   eng_operand;
  logic [MW-1:0]   eng_mode;
  logic            eng_done;
  logic [DW-1:0]   eng_result;
  logic            sched_idle;
  logic [GW-1:0]   grant_id;

  conv_sched #(
    .NUM_REQ        (N),
    .GRANT_W        (GW),
    .DATA_WIDTH     (DW),
    .MODE_WIDTH     (MW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_operand (req_operand),
    .req_mode    (req_mode),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .eng_start   (eng_start),
    .eng_operand (eng_operand),
    .eng_mode    (eng_mode),
    .eng_done    (eng_done),
    .eng_result  (eng_result),
    .sched_idle  (sched_idle),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic [DW-1:0] res;
    int            lat;
    int            exp_grant;
    logic [DW-1:0] exp_op;
    logic [MW-1:0] exp_mode;
    int            gap;
  } vec_t;

  vec_t tbl[11];

  // Called at a negedge with the scheduler in IDLE; returns at a negedge
  // with the scheduler back in IDLE.
  task automatic run_vec(input vec_t v);
    req_valid = v.valid;
    #1;
    chk("idle_before", 32'(sched_idle), 32'd1);
    chk("req_ready", 32'(req_ready), 32'd1 << v.exp_grant);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("eng_start", 32'(eng_start), 32'd1);
    chk("eng_operand", 32'(eng_operand), 32'(v.exp_op));
    chk("eng_mode", 32'(eng_mode), 32'(v.exp_mode));
    chk("grant_id", 32'(grant_id), 32'(v.exp_grant));
    for (int k = 0; k < v.lat; k++) begin
      @(negedge clk);
      chk("start_once", 32'(eng_start), 32'd0);
      chk("no_early_rsp", 32'(rsp_valid), 32'd0);
    end
    eng_done   = 1'b1;
    eng_result = v.res;
    @(negedge clk);
    eng_done   = 1'b0;
    eng_result = 8'hEE;
    chk("rsp_valid", 32'(rsp_valid), 32'd1 << v.exp_grant);
    chk("rsp_data", 32'(rsp_data), 32'(v.res));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    if (v.gap > 0) chk("rsp_gap", 32'(cyc - last_rsp), 32'(v.gap));
    last_rsp = cyc;
    @(negedge clk);
    chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    chk("idle_after", 32'(sched_idle), 32'd1);
    chk("rsp_data_hold", 32'(rsp_data), 32'(v.res));
  endtask

  initial begin
    // requester: 0=11/m0, 1=22/m2, 2=A5/m1, 3=44/m3
    req_operand = {8'h44, 8'hA5, 8'h22, 8'h11};
    req_mode    = {2'd3, 2'd1, 2'd2, 2'd0};
    req_valid   = '0;
    eng_done    = 1'b0;
    eng_result  = 8'hEE;
    reset       = 1'b1;

    tbl[0]  = '{4'b1111, 8'h5A, 1, 0, 8'h11, 2'd0, 0};
    tbl[1]  = '{4'b1111, 8'h5B, 1, 1, 8'h22, 2'd2, 4};
    tbl[2]  = '{4'b1111, 8'h5C, 1, 2, 8'hA5, 2'd1, 4};
    tbl[3]  = '{4'b1111, 8'h5D, 1, 3, 8'h44, 2'd3, 4};
    tbl[4]  = '{4'b1111, 8'h5E, 1, 0, 8'h11, 2'd0, 4};
    tbl[5]  = '{4'b0100, 8'h3C, 2, 2, 8'hA5, 2'd1, 0};
    tbl[6]  = '{4'b1001, 8'h81, 1, 3, 8'h44, 2'd3, 0};
    tbl[7]  = '{4'b1001, 8'h82, 3, 0, 8'h11, 2'd0, 0};
    tbl[8]  = '{4'b0001, 8'h90, 1, 0, 8'h11, 2'd0, 0};
    tbl[9]  = '{4'b0011, 8'h91, 2, 1, 8'h22, 2'd2, 0};
    tbl[10] = '{4'b0011, 8'h92, 1, 0, 8'h11, 2'd0, 0};

    repeat (2) @(negedge clk);
    chk("rst_idle", 32'(sched_idle), 32'd1);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_eng_operand", 32'(eng_operand), 32'd0);
    chk("rst_eng_mode", 32'(eng_mode), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);
    // rr_ptr now 1

    // Spurious done in IDLE, then a withdrawn request.
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    chk("spur_idle_state", 32'(sched_idle), 32'd1);
    chk("spur_idle_rsp", 32'(rsp_valid), 32'd0);
    req_valid = 4'b0010;
    #1;
    chk("withdraw_ready", 32'(req_ready), 32'b0010);
    #2;
    req_valid = '0;
    @(negedge clk);
    chk("withdraw_idle", 32'(sched_idle), 32'd1);
    chk("withdraw_no_start", 32'(eng_start), 32'd0);

    // Spurious done in ISSUE must not complete the transaction.
    req_valid = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("spur_issue_start", 32'(eng_start), 32'd1);
    eng_done   = 1'b1;
    eng_result = 8'h77;
    @(negedge clk);
    eng_done   = 1'b0;
    eng_result = 8'hEE;
    chk("spur_issue_rsp", 32'(rsp_valid), 32'd0);
    chk("spur_issue_busy", 32'(sched_idle), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("spur_issue_wait", 32'(rsp_valid), 32'd0);
    end
    eng_done   = 1'b1;
    eng_result = 8'h66;
    @(negedge clk);
    eng_done   = 1'b0;
    eng_result = 8'hEE;
    chk("spur_real_rsp", 32'(rsp_valid), 32'b0100);
    chk("spur_real_data", 32'(rsp_data), 32'h66);
    @(negedge clk);
    // rr_ptr now 3

    // Reset during WAIT, then a late done.
    req_valid = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("rstw_grant", 32'(grant_id), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstw_idle", 32'(sched_idle), 32'd1);
    chk("rstw_grant0", 32'(grant_id), 32'd0);
    chk("rstw_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    reset      = 1'b0;
    eng_done   = 1'b1;
    eng_result = 8'h99;
    @(negedge clk);
    eng_done   = 1'b0;
    eng_result = 8'hEE;
    chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rstw_still_idle", 32'(sched_idle), 32'd1);
    @(negedge clk);
    chk("rstw_no_rsp2", 32'(rsp_valid), 32'd0);
    // rr_ptr back to 0: all-valid must pick requester 0
    run_vec('{4'b1111, 8'h33, 1, 0, 8'h11, 2'd0, 0});
    // rr_ptr now 1

    // Engine never answers.
    req_valid = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("tmo_start", 32'(eng_start), 32'd1);
`ifdef CONV_SCHED_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("tmo_wait", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk("tmo_rsp", 32'(rsp_valid), 32'b0010);
    chk("tmo_err", 32'(rsp_err), 32'd1);
    chk("tmo_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    chk("tmo_idle", 32'(sched_idle), 32'd1);
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hang_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("hang_busy", 32'(sched_idle), 32'd0);
    eng_done   = 1'b1;
    eng_result = 8'h4D;
    @(negedge clk);
    eng_done   = 1'b0;
    eng_result = 8'hEE;
    chk("hang_rsp", 32'(rsp_valid), 32'b0010);
    chk("hang_data", 32'(rsp_data), 32'h4D);
    chk("hang_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
`endif
    // rr_ptr now 2; rsp_err must return to 0 on a normal completion
    run_vec('{4'b0001, 8'h21, 1, 0, 8'h11, 2'd0, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
